// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: mode codes, byte width and edge-selection helpers.
// Also used by spi_master so both ends agree on what each mode means.
package spi_slave_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        ModeZeroZero = 2'b00,
        ModeZeroOne  = 2'b01,
        ModeOneZero  = 2'b10,
        ModeOneOne   = 2'b11
    } spi_mode_e;

    typedef enum logic {
        StIdle,
        StActive
    } spi_slave_state_e;

    function automatic spi_mode_e mode_of(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

    // Modes 0 and 3 sample on the rising edge; modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input spi_mode_e mode);
        return (mode == ModeZeroZero) || (mode == ModeOneOne);
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input plus registered rise/fall pulses.
module spi_slave_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave: oversampled bus inputs, full-duplex shift registers,
// one-byte TX holding buffer and an RX byte strobe towards local logic.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter bit                    clkPolarity = 1'b0,
    parameter bit                    clkPhase    = 1'b0,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cs_i,
    input  logic                  spiClk_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [SPI_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);

    localparam spi_mode_e Mode       = mode_of(clkPolarity, clkPhase);
    localparam bit        SampleRise = sample_on_rise(Mode);

    logic w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall;
    logic w_sample, w_shift, w_tx_write, w_last_bit, w_load, w_mosi;
    logic [SPI_BYTE_W-1:0] w_load_byte, w_rx_next;

    spi_slave_state_e      r_state;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_rx_shift, r_tx_shift, r_buf, r_rx_data;
    logic                  r_buf_full, r_miso, r_miso_oe, r_rx_valid, r_underrun, r_busy;

    spi_slave_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (clkPolarity)
    ) u_clk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spiClk_i),
        .rise_o (w_clk_rise),
        .fall_o (w_clk_fall)
    );

    spi_slave_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (cs_i),
        .rise_o (w_cs_rise),
        .fall_o (w_cs_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
        end
    end

    always_comb begin
        w_mosi      = r_mosi_sync[SYNC_STAGES-1];
        w_sample    = SampleRise ? w_clk_rise : w_clk_fall;
        w_shift     = SampleRise ? w_clk_fall : w_clk_rise;
        w_tx_write  = tx_valid_i & ~r_buf_full;
        w_load_byte = r_buf_full ? r_buf : DEFAULT_TX;
        w_rx_next   = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};
        w_last_bit  = (r_bit_cnt == 3'd7);
        // A byte start never fires on the clock where CS goes away, so the buffer survives.
        if (r_state == StIdle) begin
            w_load = w_cs_fall & ~clkPhase;
        end else if (w_cs_rise) begin
            w_load = 1'b0;
        end else if (!clkPhase) begin
            w_load = w_sample & w_last_bit;
        end else begin
            w_load = w_shift & (r_bit_cnt == 3'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= w_load & ~r_buf_full;
            if (w_tx_write) begin
                r_buf <= tx_data_i;
            end
            // Consumption sees the pre-write state; a same-clock write stays for the next byte.
            r_buf_full <= w_tx_write | (r_buf_full & ~w_load);

            unique case (r_state)
                StIdle: begin
                    r_miso    <= 1'b0;
                    r_miso_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                    if (w_cs_fall) begin
                        r_state   <= StActive;
                        r_miso_oe <= 1'b1;
                        r_busy    <= 1'b1;
                        if (w_load) begin
                            r_tx_shift <= w_load_byte;
                            r_miso     <= w_load_byte[SPI_BYTE_W-1];
                        end
                    end
                end
                StActive: begin
                    if (w_sample) begin
                        r_rx_shift <= w_rx_next;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end
                    // CPHA=0 keeps the bit on the wire in tx_shift[7]; CPHA=1 keeps the next bit there.
                    if (w_load && !clkPhase) begin
                        r_tx_shift <= w_load_byte;
                        r_miso     <= w_load_byte[SPI_BYTE_W-1];
                    end else if (w_shift) begin
                        if (!clkPhase) begin
                            if (r_bit_cnt != 3'd0) begin
                                r_miso     <= r_tx_shift[SPI_BYTE_W-2];
                                r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
                            end
                        end else if (w_load) begin
                            r_miso     <= w_load_byte[SPI_BYTE_W-1];
                            r_tx_shift <= {w_load_byte[SPI_BYTE_W-2:0], 1'b0};
                        end else begin
                            r_miso     <= r_tx_shift[SPI_BYTE_W-1];
                            r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                    if (w_cs_rise) begin
                        r_state   <= StIdle;
                        r_bit_cnt <= '0;
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign miso_o        = r_miso;
    assign miso_oe_o     = r_miso_oe;
    assign tx_ready_o    = ~r_buf_full;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_underrun_o = r_underrun;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bus-level master model and an
// RX scoreboard fed by the stimulus and drained by a monitor on rx_valid_o.
module tb_spi_slave;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mosi = 1'b0;
    logic [3:0] sclk = 4'b1100;
    logic [3:0] csn = 4'b1111;
    logic [3:0] txv = 4'b0000;
    logic [7:0] txd = 8'h00;

    logic [3:0] miso, miso_oe, tx_ready, rx_valid, underrun, busy;
    logic [7:0] rx_data [4];

    int          sel = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rxv = 0;
    int          n_und = 0;
    logic [7:0]  exp_rx [$];
    logic [7:0]  exp_v;
    logic [7:0]  g1, g2;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave #(
            .clkPolarity (((m >> 1) & 1) != 0),
            .clkPhase    ((m & 1) != 0),
            .SYNC_STAGES (2),
            .DEFAULT_TX  (8'hFF)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .cs_i          (csn[m]),
            .spiClk_i      (sclk[m]),
            .mosi_i        (mosi),
            .miso_o        (miso[m]),
            .miso_oe_o     (miso_oe[m]),
            .tx_data_i     (txd),
            .tx_valid_i    (txv[m]),
            .tx_ready_o    (tx_ready[m]),
            .rx_data_o     (rx_data[m]),
            .rx_valid_o    (rx_valid[m]),
            .tx_underrun_o (underrun[m]),
            .busy_o        (busy[m])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_valid[sel]) begin
            n_rxv++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got %0h, required no rx_valid", rx_data[sel]);
            end else begin
                exp_v = exp_rx.pop_front();
                check("rx_data", 32'(rx_data[sel]), 32'(exp_v));
            end
        end
        if (underrun[sel]) n_und++;
    end

    task automatic push_tx(input int m, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_ready[m] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", 32'(tx_ready[m]), 32'd1);
        if (tx_ready[m]) begin
            txd    = b;
            txv[m] = 1'b1;
            @(negedge clk);
            txv[m] = 1'b0;
        end
    endtask

    task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        logic cpol, cpha;
        cpol = ((m >> 1) & 1) != 0;
        cpha = (m & 1) != 0;
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                #HALF;
                sclk[m] = ~cpol;
                rx[i] = miso[m];
                #HALF;
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = tx[i];
                #HALF;
                sclk[m] = cpol;
                rx[i] = miso[m];
                #HALF;
            end
        end
    endtask

    initial begin
        logic [7:0] mb, sb;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso[0]), 32'd0);
        check("rst_miso_oe", 32'(miso_oe[0]), 32'd0);
        check("rst_rx_data", 32'(rx_data[0]), 32'd0);
        check("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("rst_underrun", 32'(underrun[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'hF);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte in every mode; CPHA=0 reloads after the 8th bit and underruns once.
        for (int m = 0; m < 4; m++) begin
            sel = m;
            sb = (m == 0) ? 8'h3C : 8'h7E;
            mb = (m == 0) ? 8'hA5 : 8'h81;
            push_tx(m, sb);
            exp_rx.push_back(mb);
            n_rxv = 0;
            n_und = 0;
            csn[m] = 1'b0;
            #HALF;
            check("busy_active", 32'(busy[m]), 32'd1);
            check("oe_active", 32'(miso_oe[m]), 32'd1);
            spi_bits(m, mb, 8, g1);
            #HALF;
            csn[m] = 1'b1;
            #(4 * HALF);
            check("miso_byte", 32'(g1), 32'(sb));
            check("rx_count", 32'(n_rxv), 32'd1);
            check("underrun_cnt", 32'(n_und), ((m & 1) != 0) ? 32'd0 : 32'd1);
            check("busy_idle", 32'(busy[m]), 32'd0);
            check("oe_idle", 32'(miso_oe[m]), 32'd0);
        end

        // Two bytes in one frame with the buffer refilled on tx_ready.
        sel = 0;
        push_tx(0, 8'h56);
        exp_rx.push_back(8'h12);
        exp_rx.push_back(8'h34);
        n_rxv = 0;
        n_und = 0;
        fork
            push_tx(0, 8'h78);
            begin
                csn[0] = 1'b0;
                #HALF;
                spi_bits(0, 8'h12, 8, g1);
                spi_bits(0, 8'h34, 8, g2);
                #HALF;
                csn[0] = 1'b1;
            end
        join
        #(4 * HALF);
        check("two_byte_miso0", 32'(g1), 32'h56);
        check("two_byte_miso1", 32'(g2), 32'h78);
        check("two_byte_rx_count", 32'(n_rxv), 32'd2);
        check("two_byte_underrun", 32'(n_und), 32'd1);

        // Empty buffer at byte start (mode 1): default byte and a single underrun pulse.
        sel = 1;
        exp_rx.push_back(8'h5A);
        n_rxv = 0;
        n_und = 0;
        csn[1] = 1'b0;
        #HALF;
        spi_bits(1, 8'h5A, 8, g1);
        #HALF;
        csn[1] = 1'b1;
        #(4 * HALF);
        check("underrun_miso", 32'(g1), 32'hFF);
        check("underrun_pulses", 32'(n_und), 32'd1);
        check("underrun_rx_count", 32'(n_rxv), 32'd1);

        // Abort after 5 bits: no byte, buffered TX byte kept for the next frame.
        sel = 0;
        n_rxv = 0;
        csn[0] = 1'b0;
        #HALF;
        push_tx(0, 8'hC3);
        spi_bits(0, 8'hF0, 5, g1);
        #HALF;
        csn[0] = 1'b1;
        #(4 * HALF);
        check("abort_rx_count", 32'(n_rxv), 32'd0);
        check("abort_rx_hold", 32'(rx_data[0]), 32'h34);
        check("abort_buf_kept", 32'(tx_ready[0]), 32'd0);
        exp_rx.push_back(8'h0F);
        csn[0] = 1'b0;
        #HALF;
        spi_bits(0, 8'h0F, 8, g1);
        #HALF;
        csn[0] = 1'b1;
        #(4 * HALF);
        check("after_abort_miso", 32'(g1), 32'hC3);
        check("after_abort_rx_count", 32'(n_rxv), 32'd1);

        // Reset after 3 bits with a full buffer.
        push_tx(0, 8'h11);
        csn[0] = 1'b0;
        #HALF;
        push_tx(0, 8'h22);
        spi_bits(0, 8'hF5, 3, g1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", 32'(miso[0]), 32'd0);
        check("mid_rst_oe", 32'(miso_oe[0]), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data[0]), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("mid_rst_underrun", 32'(underrun[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready[0]), 32'd1);
        csn[0] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        push_tx(0, 8'h69);
        exp_rx.push_back(8'h96);
        n_rxv = 0;
        csn[0] = 1'b0;
        #HALF;
        spi_bits(0, 8'h96, 8, g1);
        #HALF;
        csn[0] = 1'b1;
        #(4 * HALF);
        check("post_rst_miso", 32'(g1), 32'h69);
        check("post_rst_rx_count", 32'(n_rxv), 32'd1);

        check("scoreboard_empty", 32'(exp_rx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
